// File: rtl/processor_io_peer.sv
// External-device end of the Processor byte I/O port: host-side TX/RX FIFOs bridged to
// the Processor's 4-phase in/inDataReady/inACK and out/outDataReady/outACK handshakes.
module processor_io_peer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  // host TX FIFO (bytes toward the Processor)
  input  logic             tx_wr_en,
  input  logic [WIDTH-1:0] tx_wr_data,
  output logic             tx_full,
  output logic [AW:0]      tx_level,
  // host RX FIFO (bytes from the Processor)
  input  logic             rx_rd_en,
  output logic [WIDTH-1:0] rx_rd_data,
  output logic             rx_empty,
  output logic [AW:0]      rx_level,
  // Processor input side
  output logic [WIDTH-1:0] in,
  output logic             inDataReady,
  input  logic             inACK,
  // Processor output side
  input  logic [WIDTH-1:0] out,
  input  logic             outDataReady,
  output logic             outACK
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    T_IDLE,
    T_REQ,
    T_REL
  } txState_t;

  typedef enum logic {
    R_IDLE,
    R_ACK
  } rxState_t;

  txState_t txState, txNext;
  rxState_t rxState, rxNext;

  logic [WIDTH-1:0] txMem [DEPTH];
  logic [WIDTH-1:0] rxMem [DEPTH];
  logic [AW-1:0]    txWrPtr, txRdPtr;
  logic [AW-1:0]    rxWrPtr, rxRdPtr;

  logic txPush, txPop;
  logic rxPush, rxPop;
  logic txEmpty, rxFull;

  // ---------------------------------------------------------------------------
  // Flags and FIFO enables
  // ---------------------------------------------------------------------------
  assign tx_full  = (tx_level == FULL_LEVEL);
  assign txEmpty  = (tx_level == '0);
  assign rxFull   = (rx_level == FULL_LEVEL);
  assign rx_empty = (rx_level == '0);

  // A full TX FIFO still accepts a push when the FSM drains the head that cycle.
  assign txPush = tx_wr_en && (!tx_full || txPop);
  assign rxPop  = rx_rd_en && !rx_empty;

  assign rx_rd_data  = rxMem[rxRdPtr];
  assign inDataReady = (txState == T_REQ);
  assign outACK      = (rxState == R_ACK);

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: storage arrays carry no reset; emptiness is tracked by the pointers and
  // levels, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr] <= tx_wr_data;
    if (rxPush) rxMem[rxWrPtr] <= out;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txWrPtr  <= '0;
      txRdPtr  <= '0;
      tx_level <= '0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + 1'b1;
      if (txPop)  txRdPtr <= txRdPtr + 1'b1;
      unique case ({txPush, txPop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: tx_level <= tx_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxWrPtr  <= '0;
      rxRdPtr  <= '0;
      rx_level <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
      if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
      unique case ({rxPush, rxPop})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: rx_level <= rx_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX handshake FSM: FIFO head -> in/inDataReady, waits for inACK rise and fall
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) txState <= T_IDLE;
    else        txState <= txNext;
  end

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    txNext = txState;
    txPop  = 1'b0;
    unique case (txState)
      T_IDLE: begin
        if (!txEmpty) begin
          txPop  = 1'b1;
          txNext = T_REQ;
        end
      end
      T_REQ: begin
        if (inACK) txNext = T_REL;
      end
      T_REL: begin
        if (!inACK) txNext = T_IDLE;
      end
      default: txNext = T_IDLE;
    endcase
  end

  // 'in' only loads on a pop, which happens in T_IDLE, so it is stable while requesting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     in <= '0;
    else if (txPop) in <= txMem[txRdPtr];
  end

  // ---------------------------------------------------------------------------
  // RX handshake FSM: one push per outDataReady request, back-pressure when full
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rxState <= R_IDLE;
    else        rxState <= rxNext;
  end

  always_comb begin
    rxNext = rxState;
    rxPush = 1'b0;
    unique case (rxState)
      R_IDLE: begin
        if (outDataReady && !rxFull) begin
          rxPush = 1'b1;
          rxNext = R_ACK;
        end
      end
      R_ACK: begin
        if (!outDataReady) rxNext = R_IDLE;
      end
      default: rxNext = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_processor_io_peer.sv
// Directed bench for processor_io_peer: plays both the host and the Processor side
// of the handshakes and checks every expected value against hand-computed constants.
module tb_processor_io_peer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             tx_wr_en;
  logic [WIDTH-1:0] tx_wr_data;
  logic             tx_full;
  logic [AW:0]      tx_level;
  logic             rx_rd_en;
  logic [WIDTH-1:0] rx_rd_data;
  logic             rx_empty;
  logic [AW:0]      rx_level;
  logic [WIDTH-1:0] in;
  logic             inDataReady;
  logic             inACK;
  logic [WIDTH-1:0] out;
  logic             outDataReady;
  logic             outACK;

  int total = 0;
  int bad   = 0;

  processor_io_peer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_wr_en     (tx_wr_en),
    .tx_wr_data   (tx_wr_data),
    .tx_full      (tx_full),
    .tx_level     (tx_level),
    .rx_rd_en     (rx_rd_en),
    .rx_rd_data   (rx_rd_data),
    .rx_empty     (rx_empty),
    .rx_level     (rx_level),
    .in           (in),
    .inDataReady  (inDataReady),
    .inACK        (inACK),
    .out          (out),
    .outDataReady (outDataReady),
    .outACK       (outACK)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr_en   = 1'b1;
    tx_wr_data = b;
    tick();
    tx_wr_en   = 1'b0;
  endtask

  // Processor side: wait for a request, check the byte, ACK after ackDelay clocks.
  task automatic proc_take(input logic [7:0] exp, input int ackDelay, input string name);
    int n = 0;
    while (!inDataReady && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (inDataReady !== 1'b1) begin
      bad++;
      $display("FAIL %s: inDataReady=%b after %0d clk, required 1", name, inDataReady, n);
      return;
    end
    total++;
    if (in !== exp) begin
      bad++;
      $display("FAIL %s: in=%h required %h", name, in, exp);
    end
    repeat (ackDelay) tick();
    inACK = 1'b1;
    tick();
    total++;
    if (inDataReady !== 1'b0) begin
      bad++;
      $display("FAIL %s req fall: inDataReady=%b required 0", name, inDataReady);
    end
    inACK = 1'b0;
  endtask

  // Processor side: offer a byte, release as soon as outACK is seen.
  task automatic proc_send(input logic [7:0] b, input string name);
    int n = 0;
    out          = b;
    outDataReady = 1'b1;
    do begin
      tick();
      n++;
    end while (!outACK && n < 50);
    total++;
    if (outACK !== 1'b1) begin
      bad++;
      $display("FAIL %s: outACK=%b after %0d clk, required 1", name, outACK, n);
    end
    outDataReady = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (outACK && n < 50);
    total++;
    if (outACK !== 1'b0) begin
      bad++;
      $display("FAIL %s release: outACK=%b required 0", name, outACK);
    end
  endtask

  task automatic pop_rx(input logic [7:0] exp, input string name);
    total++;
    if (rx_rd_data !== exp) begin
      bad++;
      $display("FAIL %s: rx_rd_data=%h required %h", name, rx_rd_data, exp);
    end
    rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    total++;
    if ({in, inDataReady, outACK, tx_full, rx_empty, tx_level, rx_level} !==
        {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0}) begin
      bad++;
      $display("FAIL reset state: in=%h req=%b ack=%b full=%b empty=%b txl=%0d rxl=%0d required 00 0 0 0 1 0 0",
               in, inDataReady, outACK, tx_full, rx_empty, tx_level, rx_level);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_tx_basic();
    push_tx(8'hA5);
    total++;
    if (tx_level !== 3'd1) begin
      bad++;
      $display("FAIL tx first push level: tx_level=%0d required 1", tx_level);
    end
    push_tx(8'h3C);
    // A5 has moved into 'in', 3C waits in the FIFO.
    total++;
    if (tx_level !== 3'd1) begin
      bad++;
      $display("FAIL tx second push level: tx_level=%0d required 1", tx_level);
    end
    proc_take(8'hA5, 1, "tx byte A5");
    proc_take(8'h3C, 1, "tx byte 3C");
    repeat (2) tick();
    total++;
    if (tx_level !== 3'd0 || in !== 8'h3C) begin
      bad++;
      $display("FAIL tx drained: tx_level=%0d in=%h required 0 3c", tx_level, in);
    end
    inACK = 1'b1;
    repeat (3) tick();
    total++;
    if (inDataReady !== 1'b0 || tx_level !== 3'd0) begin
      bad++;
      $display("FAIL idle inACK: req=%b tx_level=%0d required 0 0", inDataReady, tx_level);
    end
    inACK = 1'b0;
    tick();
  endtask

  task automatic test_rx_basic();
    proc_send(8'h11, "rx send 11");
    proc_send(8'h22, "rx send 22");
    proc_send(8'h33, "rx send 33");
    total++;
    if (rx_level !== 3'd3 || rx_rd_data !== 8'h11) begin
      bad++;
      $display("FAIL rx three bytes: rx_level=%0d head=%h required 3 11", rx_level, rx_rd_data);
    end
    pop_rx(8'h11, "rx pop 11");
    pop_rx(8'h22, "rx pop 22");
    pop_rx(8'h33, "rx pop 33");
    total++;
    if (rx_empty !== 1'b1 || rx_level !== 3'd0) begin
      bad++;
      $display("FAIL rx drained: empty=%b rx_level=%0d required 1 0", rx_empty, rx_level);
    end
    rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
    total++;
    if (rx_empty !== 1'b1 || rx_level !== 3'd0) begin
      bad++;
      $display("FAIL rx pop when empty: empty=%b rx_level=%0d required 1 0", rx_empty, rx_level);
    end
  endtask

  task automatic test_rx_backpressure();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) proc_send(8'(8'h41 + i), "rx fill");
    out          = 8'h77;
    outDataReady = 1'b1;
    repeat (5) begin
      tick();
      total++;
      if (outACK !== 1'b0 || rx_level !== 3'd4) begin
        bad++;
        $display("FAIL rx backpressure: outACK=%b rx_level=%0d required 0 4", outACK, rx_level);
      end
    end
    pop_rx(8'h41, "rx pop 41");
    while (!outACK && n < 2) begin
      tick();
      n++;
    end
    total++;
    if (outACK !== 1'b1) begin
      bad++;
      $display("FAIL rx ack after pop: outACK=%b required 1 within 2 clk", outACK);
    end
    outDataReady = 1'b0;
    tick();
    pop_rx(8'h42, "rx pop 42");
    pop_rx(8'h43, "rx pop 43");
    pop_rx(8'h44, "rx pop 44");
    pop_rx(8'h77, "rx pop 77");
    total++;
    if (rx_empty !== 1'b1) begin
      bad++;
      $display("FAIL rx empty after 77: empty=%b required 1", rx_empty);
    end
  endtask

  task automatic test_tx_full_wrap();
    for (int i = 0; i <= DEPTH; i++) push_tx(8'(8'h80 + i));
    total++;
    if (tx_full !== 1'b1 || tx_level !== 3'd4 || in !== 8'h80 || inDataReady !== 1'b1) begin
      bad++;
      $display("FAIL tx full: full=%b level=%0d in=%h req=%b required 1 4 80 1",
               tx_full, tx_level, in, inDataReady);
    end
    push_tx(8'hEE);
    total++;
    if (tx_level !== 3'd4) begin
      bad++;
      $display("FAIL tx push when full: tx_level=%0d required 4", tx_level);
    end
    for (int i = 0; i <= DEPTH; i++) proc_take(8'(8'h80 + i), 0, "tx wrap drain");
    for (int i = 0; i < 3; i++) push_tx(8'(8'h85 + i));
    for (int i = 0; i < 3; i++) proc_take(8'(8'h85 + i), 2, "tx wrap second lap");
    repeat (3) tick();
    total++;
    if (tx_level !== 3'd0 || tx_full !== 1'b0 || inDataReady !== 1'b0) begin
      bad++;
      $display("FAIL tx after wrap: level=%0d full=%b req=%b required 0 0 0",
               tx_level, tx_full, inDataReady);
    end
  endtask

  task automatic test_rx_hold();
    out          = 8'h5A;
    outDataReady = 1'b1;
    repeat (10) tick();
    total++;
    if (rx_level !== 3'd1 || outACK !== 1'b1) begin
      bad++;
      $display("FAIL rx long request: rx_level=%0d outACK=%b required 1 1", rx_level, outACK);
    end
    outDataReady = 1'b0;
    tick();
    total++;
    if (outACK !== 1'b0) begin
      bad++;
      $display("FAIL rx ack fall: outACK=%b required 0", outACK);
    end
    pop_rx(8'h5A, "rx pop 5a");
  endtask

  task automatic test_reset_mid();
    push_tx(8'h90);
    push_tx(8'h91);
    out          = 8'h66;
    outDataReady = 1'b1;
    push_tx(8'h92);
    total++;
    if (inDataReady !== 1'b1 || tx_level !== 3'd2 || outACK !== 1'b1 || rx_level !== 3'd1) begin
      bad++;
      $display("FAIL pre-reset: req=%b txl=%0d ack=%b rxl=%0d required 1 2 1 1",
               inDataReady, tx_level, outACK, rx_level);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (inDataReady !== 1'b0 || tx_level !== 3'd0 || outACK !== 1'b0 ||
        rx_level !== 3'd0 || in !== 8'h00) begin
      bad++;
      $display("FAIL async reset: req=%b txl=%0d ack=%b rxl=%0d in=%h required 0 0 0 0 00",
               inDataReady, tx_level, outACK, rx_level, in);
    end
    outDataReady = 1'b0;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    total++;
    if (inDataReady !== 1'b0 || tx_level !== 3'd0 || rx_empty !== 1'b1) begin
      bad++;
      $display("FAIL after reset release: req=%b txl=%0d empty=%b required 0 0 1",
               inDataReady, tx_level, rx_empty);
    end
    push_tx(8'h93);
    proc_take(8'h93, 1, "tx after reset");
  endtask

  initial begin
    reset        = 1'b0;
    tx_wr_en     = 1'b0;
    tx_wr_data   = '0;
    rx_rd_en     = 1'b0;
    inACK        = 1'b0;
    out          = '0;
    outDataReady = 1'b0;

    test_reset();
    test_tx_basic();
    test_rx_basic();
    test_rx_backpressure();
    test_tx_full_wrap();
    test_rx_hold();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
